// File: rtl/alu_req_arbiter_if.sv
// Requester-side bus of alu_req_arbiter: two request/operand ports plus the shared
// one-hot ack, error flag, result, busy and grant index.
interface alu_req_arbiter_if #(
  parameter int unsigned W = 16
);
  logic [1:0]     req_i;
  logic [3:0]     op0_i;
  logic [W-1:0]   a0_i;
  logic [W-1:0]   b0_i;
  logic [3:0]     op1_i;
  logic [W-1:0]   a1_i;
  logic [W-1:0]   b1_i;
  logic [1:0]     ack_o;
  logic           err_o;
  logic [2*W-1:0] result_o;
  logic           busy_o;
  logic           gnt_id_o;

  // Arbiter side.
  modport slave (
    input  req_i, op0_i, a0_i, b0_i, op1_i, a1_i, b1_i,
    output ack_o, err_o, result_o, busy_o, gnt_id_o
  );

  // Requester side.
  modport master (
    output req_i, op0_i, a0_i, b0_i, op1_i, a1_i, b1_i,
    input  ack_o, err_o, result_o, busy_o, gnt_id_o
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; all outputs registered.
// Define ARB_TIMEOUT_EN to add a WAIT-state watchdog of TIMEOUT_CYC cycles.
module alu_req_arbiter #(
  parameter int unsigned W = 16
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 64
`endif
) (
  input  logic                  clk,
  input  logic                  rst_b,
  alu_req_arbiter_if.slave      req_bus,
  output logic [3:0]            alu_s,
  output logic [W-1:0]          alu_a,
  output logic [W-1:0]          alu_b,
  output logic                  alu_start,
  input  logic                  alu_finish,
  input  logic [2*W-1:0]        alu_result
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  localparam logic [3:0] MaxLegalOp = 4'd3;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned    CntW     = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT_CYC - 1);
  localparam logic [CntW-1:0] CntMax   = '1;

  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  logic [1:0]     state_q, state_d;
  logic           last_q, last_d;
  logic           err_flag_q, err_flag_d;
  logic           gnt_q, gnt_d;
  logic [3:0]     alu_s_q, alu_s_d;
  logic [W-1:0]   alu_a_q, alu_a_d;
  logic [W-1:0]   alu_b_q, alu_b_d;
  logic           alu_start_q, alu_start_d;
  logic [1:0]     ack_q, ack_d;
  logic           err_q, err_d;
  logic [2*W-1:0] result_q, result_d;
  logic           busy_q, busy_d;

  logic           win_id;
  logic [3:0]     op_sel;
  logic [W-1:0]   a_sel;
  logic [W-1:0]   b_sel;

  // A lone requester always wins; on a tie the one not served last wins.
  always_comb begin
    if (req_bus.req_i == 2'b01) begin
      win_id = 1'b0;
    end else if (req_bus.req_i == 2'b10) begin
      win_id = 1'b1;
    end else begin
      win_id = ~last_q;
    end
    op_sel = win_id ? req_bus.op1_i : req_bus.op0_i;
    a_sel  = win_id ? req_bus.a1_i  : req_bus.a0_i;
    b_sel  = win_id ? req_bus.b1_i  : req_bus.b0_i;
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    err_flag_d = err_flag_q;
    gnt_d      = gnt_q;
    alu_s_d    = alu_s_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    result_d   = result_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif

    case (state_q)
      StIdle: begin
        if (req_bus.req_i != 2'b00) begin
          gnt_d   = win_id;
          alu_s_d = op_sel;
          alu_a_d = a_sel;
          alu_b_d = b_sel;
          if (op_sel <= MaxLegalOp) begin
            state_d    = StStart;
            err_flag_d = 1'b0;
          end else begin
            // Illegal opcode never reaches the ALU.
            state_d    = StResp;
            err_flag_d = 1'b1;
            result_d   = '0;
          end
        end
      end

      StStart: begin
        state_d = StWait;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end

      StWait: begin
        if (alu_finish) begin
          state_d    = StResp;
          err_flag_d = 1'b0;
          result_d   = alu_result;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q >= CntLimit) begin
          state_d    = StResp;
          err_flag_d = 1'b1;
          result_d   = '0;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end

      StResp: begin
        state_d = StIdle;
        last_d  = gnt_q;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output strobes lag the state by one edge so every port comes straight from a flop.
  always_comb begin
    alu_start_d = (state_q == StStart);
    ack_d       = 2'b00;
    err_d       = 1'b0;
    if (state_q == StResp) begin
      ack_d[gnt_q] = 1'b1;
      err_d        = err_flag_q;
    end
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q     <= StIdle;
      last_q      <= 1'b1;
      err_flag_q  <= 1'b0;
      gnt_q       <= 1'b0;
      alu_s_q     <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_start_q <= 1'b0;
      ack_q       <= 2'b00;
      err_q       <= 1'b0;
      result_q    <= '0;
      busy_q      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      err_flag_q  <= err_flag_d;
      gnt_q       <= gnt_d;
      alu_s_q     <= alu_s_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_start_q <= alu_start_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign alu_s     = alu_s_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_start = alu_start_q;

  assign req_bus.ack_o    = ack_q;
  assign req_bus.err_o    = err_q;
  assign req_bus.result_o = result_q;
  assign req_bus.busy_o   = busy_q;
  assign req_bus.gnt_id_o = gnt_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: vector table, directed corner sequences and a
// randomized two-requester phase checked by a transaction-level scoreboard.
module tb_alu_req_arbiter;

  localparam int TOUT = 8;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [3:0]  alu_s;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_start;
  logic        alu_finish;
  logic [31:0] model_res = 32'd0;
  logic        model_fin = 1'b0;
  logic        force_fin = 1'b0;

  // ALU model controls and monitors.
  bit model_hang = 1'b0;
  bit rand_lat   = 1'b0;
  int lat_cfg    = 1;
  int alu_cnt    = 0;
  int start_cnt  = 0;
  int start_viol = 0;
  bit start_prev = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  alu_req_arbiter_if #(.W(16)) bus ();

  assign alu_finish = model_fin | force_fin;

  alu_req_arbiter #(
    .W(16)
`ifdef ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(TOUT)
`endif
  ) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .req_bus    (bus),
    .alu_s      (alu_s),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_start  (alu_start),
    .alu_finish (alu_finish),
    .alu_result (model_res)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    case (op)
      4'd0:    alu_ref = {16'd0, a} + {16'd0, b};
      4'd1:    alu_ref = {16'd0, a - b};
      4'd2:    alu_ref = {16'd0, a} * {16'd0, b};
      4'd3:    alu_ref = (b == 16'd0) ? 32'hFFFF_FFFF : {a % b, a / b};
      default: alu_ref = 32'd0;
    endcase
  endfunction

  // Behavioural ALU: finishes lat cycles after seeing alu_start.
  always @(negedge clk) begin
    if (!rst_b) begin
      alu_cnt   = 0;
      model_fin = 1'b0;
    end else begin
      model_fin = 1'b0;
      if (alu_start) begin
        start_cnt++;
        if (start_prev) start_viol++;
        if (model_hang) alu_cnt = 0;
        else if (rand_lat) alu_cnt = int'($urandom_range(1, 5));
        else alu_cnt = lat_cfg;
      end else if (alu_cnt > 0) begin
        alu_cnt--;
        if (alu_cnt == 0) begin
          model_fin = 1'b1;
          model_res = alu_ref(alu_s, alu_a, alu_b);
        end
      end
    end
    start_prev = alu_start;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_req(input int r, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b);
    if (r == 0) begin
      bus.op0_i = op; bus.a0_i = a; bus.b0_i = b;
    end else begin
      bus.op1_i = op; bus.a1_i = a; bus.b1_i = b;
    end
    bus.req_i[r] = 1'b1;
  endtask

  // Called at a negedge; returns at the negedge where ack_o is first seen.
  task automatic wait_ack(input int budget, output int edges, output bit ok);
    edges = 0;
    ok    = 1'b0;
    while (edges < budget && !ok) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (bus.ack_o != 2'b00) ok = 1'b1;
    end
  endtask

  task automatic chk_cleared(input string p);
    chk({p, "_ack"},   64'(bus.ack_o),    64'd0);
    chk({p, "_err"},   64'(bus.err_o),    64'd0);
    chk({p, "_res"},   64'(bus.result_o), 64'd0);
    chk({p, "_busy"},  64'(bus.busy_o),   64'd0);
    chk({p, "_gnt"},   64'(bus.gnt_id_o), 64'd0);
    chk({p, "_start"}, 64'(alu_start),    64'd0);
    chk({p, "_s"},     64'(alu_s),        64'd0);
    chk({p, "_a"},     64'(alu_a),        64'd0);
    chk({p, "_b"},     64'(alu_b),        64'd0);
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    int          lat;
    logic [1:0]  ack;
    logic        err;
    logic [31:0] res;
    int          starts;
    int          edges;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int          edges;
    bit          ok;
    int          s0;
    int          r;
    int          must_next;
    int          legal;
    int          pend[2];
    int          idle[2];
    logic [3:0]  t_op[2];
    logic [15:0] t_a[2];
    logic [15:0] t_b[2];
    logic [1:0]  acked;
    bit          exp_err;
    logic [31:0] exp_res;
    int          bad;

    vecs[0] = '{2'b01, 4'd0,  16'd5,      16'd7,      3, 2'b01, 1'b0, 32'd12,        1, 7};
    vecs[1] = '{2'b10, 4'd1,  16'd9,      16'd2,      2, 2'b10, 1'b0, 32'd7,         1, 6};
    vecs[2] = '{2'b01, 4'd2,  16'hFFFF,   16'hFFFF,   1, 2'b01, 1'b0, 32'hFFFE_0001, 1, 5};
    vecs[3] = '{2'b10, 4'd3,  16'd100,    16'd7,      4, 2'b10, 1'b0, 32'h0002_000E, 1, 8};
    vecs[4] = '{2'b10, 4'd9,  16'd1,      16'd1,      1, 2'b10, 1'b1, 32'd0,         0, 2};
    vecs[5] = '{2'b01, 4'd15, 16'd3,      16'd3,      1, 2'b01, 1'b1, 32'd0,         0, 2};
    vecs[6] = '{2'b01, 4'd0,  16'hFFFF,   16'd1,      5, 2'b01, 1'b0, 32'h0001_0000, 1, 9};
    vecs[7] = '{2'b10, 4'd1,  16'd2,      16'd9,      1, 2'b10, 1'b0, 32'h0000_FFF9, 1, 5};

    bus.req_i = 2'b00;
    bus.op0_i = 4'd0; bus.a0_i = 16'd0; bus.b0_i = 16'd0;
    bus.op1_i = 4'd0; bus.a1_i = 16'd0; bus.b1_i = 16'd0;
    rst_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cleared("reset");
    rst_b = 1'b1;

    // Vector table: single transactions, latency measured in edges.
    foreach (vecs[i]) begin
      @(negedge clk);
      lat_cfg = vecs[i].lat;
      s0 = start_cnt;
      set_req(vecs[i].req[1] ? 1 : 0, vecs[i].op, vecs[i].a, vecs[i].b);
      wait_ack(60, edges, ok);
      bus.req_i = 2'b00;
      chk($sformatf("v%0d_ack_seen", i), 64'(ok), 64'd1);
      chk($sformatf("v%0d_ack", i), 64'(bus.ack_o), 64'(vecs[i].ack));
      chk($sformatf("v%0d_err", i), 64'(bus.err_o), 64'(vecs[i].err));
      chk($sformatf("v%0d_res", i), 64'(bus.result_o), 64'(vecs[i].res));
      chk($sformatf("v%0d_gnt", i), 64'(bus.gnt_id_o), 64'(vecs[i].req[1]));
      chk($sformatf("v%0d_busy", i), 64'(bus.busy_o), 64'd0);
      chk($sformatf("v%0d_edges", i), 64'(edges), 64'(vecs[i].edges));
      chk($sformatf("v%0d_starts", i), 64'(start_cnt - s0), 64'(vecs[i].starts));
      @(negedge clk);
      chk($sformatf("v%0d_ack_1cyc", i), 64'(bus.ack_o), 64'd0);
    end

    // Tie: requester 0 first, then 1.
    @(negedge clk);
    lat_cfg = 2;
    s0 = start_cnt;
    set_req(0, 4'd2, 16'd3, 16'd4);
    set_req(1, 4'd1, 16'd9, 16'd2);
    wait_ack(60, edges, ok);
    bus.req_i[0] = 1'b0;
    chk("tie_first_ack", 64'(bus.ack_o), 64'd1);
    chk("tie_first_res", 64'(bus.result_o), 64'd12);
    chk("tie_first_gnt", 64'(bus.gnt_id_o), 64'd0);
    wait_ack(60, edges, ok);
    bus.req_i[1] = 1'b0;
    chk("tie_second_ack", 64'(bus.ack_o), 64'd2);
    chk("tie_second_res", 64'(bus.result_o), 64'd7);
    chk("tie_second_gnt", 64'(bus.gnt_id_o), 64'd1);
    chk("tie_starts", 64'(start_cnt - s0), 64'd2);

    // Both held for four transactions: strict alternation.
    @(negedge clk);
    set_req(0, 4'd0, 16'd1, 16'd1);
    set_req(1, 4'd0, 16'd2, 16'd2);
    for (int k = 0; k < 4; k++) begin
      wait_ack(60, edges, ok);
      chk($sformatf("b2b%0d_ack", k), 64'(bus.ack_o), (k % 2 == 0) ? 64'd1 : 64'd2);
      chk($sformatf("b2b%0d_res", k), 64'(bus.result_o), (k % 2 == 0) ? 64'd2 : 64'd4);
    end
    bus.req_i = 2'b00;
    repeat (3) @(negedge clk);
    chk("b2b_idle_busy", 64'(bus.busy_o), 64'd0);

    // Reset in WAIT: leave last-served at 0 first so a tie would otherwise pick 1.
    set_req(0, 4'd0, 16'd4, 16'd4);
    wait_ack(60, edges, ok);
    bus.req_i = 2'b00;
    chk("rst_pre_ack", 64'(bus.ack_o), 64'd1);
    @(negedge clk);
    model_hang = 1'b1;
    set_req(1, 4'd0, 16'd3, 16'd4);
    repeat (6) @(negedge clk);
    chk("rst_pre_busy", 64'(bus.busy_o), 64'd1);
    rst_b = 1'b0;
    bus.req_i = 2'b00;
    @(negedge clk);
    rst_b = 1'b1;
    chk_cleared("rstwait");
    force_fin = 1'b1;
    @(negedge clk);
    force_fin = 1'b0;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.ack_o != 2'b00 || bus.busy_o) bad++;
    end
    chk("rstwait_stray_finish", 64'(bad), 64'd0);
    model_hang = 1'b0;
    lat_cfg = 1;
    set_req(0, 4'd0, 16'd1, 16'd2);
    set_req(1, 4'd0, 16'd3, 16'd4);
    wait_ack(60, edges, ok);
    bus.req_i[0] = 1'b0;
    chk("rstwait_tie_ack", 64'(bus.ack_o), 64'd1);
    wait_ack(60, edges, ok);
    bus.req_i[1] = 1'b0;
    chk("rstwait_tie_second", 64'(bus.ack_o), 64'd2);

    // Watchdog.
    @(negedge clk);
    model_hang = 1'b1;
    set_req(0, 4'd0, 16'd7, 16'd7);
`ifdef ARB_TIMEOUT_EN
    wait_ack(100, edges, ok);
    bus.req_i = 2'b00;
    chk("tout_ack", 64'(bus.ack_o), 64'd1);
    chk("tout_err", 64'(bus.err_o), 64'd1);
    chk("tout_res", 64'(bus.result_o), 64'd0);
    chk("tout_edges", 64'(edges), 64'(TOUT + 3));
    @(negedge clk);
    model_hang = 1'b0;
    lat_cfg = TOUT - 1;
    set_req(1, 4'd0, 16'd7, 16'd8);
    wait_ack(100, edges, ok);
    bus.req_i = 2'b00;
    chk("tout_tie_ack", 64'(bus.ack_o), 64'd2);
    chk("tout_tie_err", 64'(bus.err_o), 64'd0);
    chk("tout_tie_res", 64'(bus.result_o), 64'd15);
    chk("tout_tie_edges", 64'(edges), 64'(TOUT + 3));
`else
    wait_ack(100, edges, ok);
    chk("notout_no_ack", 64'(ok), 64'd0);
    chk("notout_busy", 64'(bus.busy_o), 64'd1);
    rst_b = 1'b0;
    bus.req_i = 2'b00;
    @(negedge clk);
    rst_b = 1'b1;
    model_hang = 1'b0;
`endif

    // Random phase with a transaction-level scoreboard.
    @(negedge clk);
    rand_lat  = 1'b1;
    s0        = start_cnt;
    legal     = 0;
    must_next = -1;
    pend      = '{0, 0};
    idle      = '{0, 0};
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      acked = 2'b00;
      if (bus.ack_o != 2'b00) begin
        r = bus.ack_o[1] ? 1 : 0;
        chk("rnd_ack_valid", 64'(($onehot(bus.ack_o) && pend[r] != 0) ? 1 : 0), 64'd1);
        if (must_next >= 0) chk("rnd_rr_order", 64'(r), 64'(must_next));
        exp_err = (t_op[r] > 4'd3);
        exp_res = exp_err ? 32'd0 : alu_ref(t_op[r], t_a[r], t_b[r]);
        chk("rnd_err", 64'(bus.err_o), 64'(exp_err));
        chk("rnd_res", 64'(bus.result_o), 64'(exp_res));
        chk("rnd_gnt", 64'(bus.gnt_id_o), 64'(r));
        if (!exp_err) legal++;
        must_next = (pend[1 - r] != 0) ? 1 - r : -1;
        pend[r] = 0;
        bus.req_i[r] = 1'b0;
        idle[r] = int'($urandom_range(0, 3));
        acked[r] = 1'b1;
      end
      if (cyc < 2800) begin
        for (int i = 0; i < 2; i++) begin
          if (pend[i] == 0 && !acked[i]) begin
            if (idle[i] > 0) begin
              idle[i]--;
            end else if ($urandom_range(0, 2) == 0) begin
              t_op[i] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(4, 15))
                                                    : 4'($urandom_range(0, 3));
              t_a[i]  = 16'($urandom);
              t_b[i]  = 16'($urandom);
              set_req(i, t_op[i], t_a[i], t_b[i]);
              pend[i] = 1;
            end
          end
        end
      end
    end
    chk("rnd_drained", 64'(pend[0] + pend[1]), 64'd0);
    chk("rnd_start_count", 64'(start_cnt - s0), 64'(legal));
    chk("start_pulse_width", 64'(start_viol), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares one 16-bit ALU (Control_Unit plus datapath) between two requesters, e.g. two issue ports.
- Round-robin arbitration; latches the winner's opcode and operands; pulses the ALU start; waits for ALU finish; returns the result with a one-cycle ack.
- Sits directly above the ALU control unit and owns its s/start inputs.

Parameters:
W, 16, operand width; result is 2*W (MUL/DIV produce a two-word result).
TIMEOUT_CYC, 64, watchdog limit in cycles (used only with ARB_TIMEOUT_EN).

Ports:
clk  in  1  clock; all logic on rising edge.
rst_b  in  1  synchronous active-low reset.
req_i  in  2  per-requester request level; held with op/operands until that requester's ack.
op0_i  in  4  requester 0 opcode (0 ADD, 1 SUB, 2 MUL, 3 DIV).
a0_i, b0_i  in  W  requester 0 operands.
op1_i  in  4  requester 1 opcode.
a1_i, b1_i  in  W  requester 1 operands.
ack_o  out  2  one-hot, one-cycle completion pulse per requester.
err_o  out  1  valid with ack; 1 = illegal opcode (or timeout).
result_o  out  2W  valid with ack; 0 when err_o=1.
busy_o  out  1  high in every state except IDLE.
gnt_id_o  out  1  index of the current or last granted requester.
alu_s  out  4  opcode to ALU; stable from START until the return to IDLE.
alu_a, alu_b  out  W  latched operands; stable likewise.
alu_start  out  1  one-cycle start pulse to ALU.
alu_finish  in  1  ALU completion; sampled only in WAIT.
alu_result  in  2W  ALU result; captured on the edge where alu_finish=1 in WAIT.

Behaviour:
- Reset (rst_b=0 at an edge, from any state): state=IDLE; ack_o=0, err_o=0, result_o=0, busy_o=0, alu_start=0, alu_s/alu_a/alu_b=0, gnt_id_o=0; last-served pointer=1, so requester 0 wins the first tie. Any in-flight ALU op is abandoned; the ALU shares rst_b.
- All outputs are registered.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - If req_i!=0, pick the winner: the single requester if only one; on a tie, the one not last served.
  - Latch op/a/b into alu_s/alu_a/alu_b and set gnt_id_o.
  - Opcode <=3: next state START. Opcode >3: next state RESP with err_o=1, result_o=0, no alu_start.
- START: alu_start=1 for exactly this cycle; next state WAIT.
- WAIT:
  - alu_start=0.
  - On alu_finish=1: capture alu_result into result_o, err_o=0, next state RESP.
  - Otherwise stay in WAIT.
- RESP:
  - ack_o[gnt_id_o]=1 for exactly one cycle, with result_o/err_o valid.
  - Last-served pointer := gnt_id_o; next state IDLE.
- Handshake:
  - A requester drops req in the cycle after its ack. If req is still high when IDLE samples it, that is a new transaction.
  - Requests are never preempted. A loser keeps req high and is served next.
- Latency: req sampled at edge k → alu_start high after edge k+1. alu_finish sampled at edge m → ack high after edge m+1. Minimum req→ack is 4 edges. An illegal op acks 2 edges after sampling.
- Outside RESP: ack_o=0, err_o=0. result_o holds its last value.
- alu_finish outside WAIT is ignored.
- Back-to-back: both requesters held high are served alternately 0,1,0,1.
- busy_o=1 in START, WAIT and RESP.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYC-1 without alu_finish, go to RESP with err_o=1 and result_o=0.
  - The counter saturates and is cleared by reset.
  - alu_finish on the same edge as the timeout wins (normal result).
- Undefined: no counter; WAIT waits indefinitely.

Test Plan:
- Reset then req_i=01, op0=0, a0=5, b0=7; ALU model finishes 3 cycles after start with 12 → one alu_start pulse, alu_s=0, ack_o=01 one cycle, result_o=12, err_o=0, busy_o low afterward.
- req_i=11 from reset, op0=2 (a=3,b=4), op1=1 (a=9,b=2) → requester 0 served first (result 12), then requester 1 (result 7); exactly two alu_start pulses; gnt_id_o 0 then 1.
- Both requesters held continuously for 4 transactions → ack order 01,10,01,10.
- op1=4'd9 on requester 1 → no alu_start, ack_o=10 two edges after sampling, err_o=1, result_o=0.
- rst_b=0 for one edge while in WAIT → next cycle all outputs 0, state IDLE; a later alu_finish=1 produces no ack; a subsequent tie grants requester 0.
- ARB_TIMEOUT_EN, TIMEOUT_CYC=8, ALU never finishes → ack with err_o=1 after 8 WAIT cycles. Without the macro, no ack and busy_o stays 1.
